pc_ctrl: RTL and testbench
==========================

// Module: pc_ctrl
// PURPOSE
//  Program counter and pipeline-control block. Consumes the execute stage's jump_en/jump_addr/hold_flag.
//  Generates the fetch PC and the flush/hold controls for the if_id and id_ex pipeline registers.
//  Absorbs the latency of the synchronous instruction ROM with a small flush state machine.
// PARAMETERS
//  RESET_ADDR    32'h0000_0000  pc_o value after reset
//  FLUSH_CYCLES  2              cycles flush_o stays high per redirect (>=1; 2 = one cycle + ROM latency)
//  CNT_W         16             width of redirect performance counter
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst_n          in   1      synchronous reset, active low
//  jump_en_i      in   1      execute stage: taken branch/JAL this cycle
//  jump_addr_i    in   32     execute stage: redirect target
//  hold_flag_i    in   1      execute stage: stall request
//  ext_hold_i     in   1      bus/memory stall request
//  pc_o           out  32     fetch address to instruction ROM
//  flush_o        out  1      clear if_id and id_ex to NOP this cycle
//  hold_o         out  1      freeze pc and if_id this cycle
//  fetch_valid_o  out  1      pc_o is a live fetch (not flushed, not held)
//  redirect_cnt_o out  CNT_W  count of accepted redirects, saturating
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): pc_o=RESET_ADDR, state=RUN, flush_cnt=0, redirect_cnt_o=0.
//  - Reset overrides everything, including a redirect in the same cycle.
//  - Reset mid-flush returns the state machine to RUN.
//  - State machine: RUN, FLUSH. Internal counter flush_cnt (width clog2(FLUSH_CYCLES)+1).
//  - hold = hold_flag_i | ext_hold_i. Priority per cycle: reset > jump_en_i > hold > step.
//  - RUN, jump_en_i=1:
//      flush_o=1 (combinational, same cycle).
//      Next pc_o={jump_addr_i[31:2],2'b00}; low bits are silently cleared.
//      If FLUSH_CYCLES>1: next state FLUSH, flush_cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
//      redirect_cnt_o+1, saturating at all-ones.
//  - RUN, hold, no jump:
//      hold_o=1 and pc_o unchanged.
//      flush_o=0; fetch_valid_o=0.
//  - RUN, idle: pc_o <= pc_o+4, wrapping 32'hFFFF_FFFC -> 0. fetch_valid_o=1.
//  - FLUSH:
//      flush_o=1, fetch_valid_o=0, and pc_o <= pc_o+4 (the fetch is speculative and discarded).
//      flush_cnt decrements each cycle; when flush_cnt==1, next state is RUN.
//  - FLUSH with hold:
//      pc_o and flush_cnt freeze, flush_o stays 1, hold_o=1.
//  - FLUSH with jump_en_i=1:
//      Accepted as in RUN. pc_o is reloaded and flush_cnt is restarted at FLUSH_CYCLES-1.
//  - jump_en_i with hold in the same cycle: the jump wins.
//      pc_o loads the target, hold_o=0, flush_o=1.
//  - Outputs hold_o, flush_o and fetch_valid_o are combinational from state and inputs.
//  - pc_o and redirect_cnt_o are registered.
//  - Latency: redirect target appears on pc_o exactly 1 cycle after jump_en_i.
//    The first valid fetch of the target occurs FLUSH_CYCLES cycles after jump_en_i.
// TESTING
//  1. Reset with RESET_ADDR=0:
//       rst_n low 2 cycles -> pc_o=0, flush_o=0, hold_o=0, redirect_cnt_o=0.
//       rst_n released -> pc_o 0,4,8,C with fetch_valid_o=1.
//  2. Redirect in RUN: at pc=0x10 pulse jump_en_i with jump_addr_i=0x100.
//       flush_o=1 that cycle; next cycle pc_o=0x100 with flush_o=1.
//       Then pc_o=0x104 with fetch_valid_o=1; redirect_cnt_o=1.
//  3. Hold, then hold during flush:
//       ext_hold_i high 3 cycles at pc=0x20 -> pc_o stays 0x20, hold_o=1, resumes at 0x24.
//       Redirect to 0x200 and assert hold_flag_i the next cycle ->
//         pc_o stays 0x200 and flush_o stays 1 while held; RUN resumes 1 cycle after release.
//  4. Back-to-back redirects: jump to 0x300, then in the FLUSH cycle jump to 0x400.
//       pc_o=0x400 and flush is restarted; redirect_cnt_o+=2.
//       jump_addr_i=0x503 -> pc_o=0x500.
//  5. Simultaneous events:
//       jump_en_i with ext_hold_i -> pc_o=target, hold_o=0.
//       jump_en_i with rst_n=0 -> pc_o=RESET_ADDR, redirect_cnt_o=0.
//       pc_o=32'hFFFF_FFFC idle -> pc_o wraps to 0.
//  6. Counter saturation (CNT_W=4): 17 redirects -> redirect_cnt_o=4'hF and holds there.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch program counter with redirect/hold arbitration and a short flush
// state machine that covers the one-cycle latency of the synchronous instruction ROM.
module pc_ctrl #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_flag_i,
    input  logic             ext_hold_i,
    output logic [31:0]      pc_o,
    output logic             flush_o,
    output logic             hold_o,
    output logic             fetch_valid_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);
    localparam int FW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [FW-1:0] FC_INIT = FW'(FLUSH_CYCLES - 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             hold;

    assign hold           = hold_flag_i | ext_hold_i;
    assign flush_o        = jump_en_i | (state_q == FLUSH);
    assign hold_o         = hold & ~jump_en_i;
    assign fetch_valid_o  = (state_q == RUN) & ~jump_en_i & ~hold;
    assign pc_o           = pc_q;
    assign redirect_cnt_o = rcnt_q;

    // A redirect beats a stall; a stall freezes both the pc and the flush countdown.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        rcnt_d  = rcnt_q;
        if (jump_en_i) begin
            pc_d    = jump_addr_i & ~32'h3;
            rcnt_d  = &rcnt_q ? rcnt_q : rcnt_q + 1'b1;
            state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
            fcnt_d  = FLUSH_CYCLES > 1 ? FC_INIT : '0;
        end else if (!hold) begin
            pc_d = pc_q + 32'd4;
            if (state_q == FLUSH) begin
                fcnt_d  = fcnt_q - 1'b1;
                state_d = fcnt_q == FW'(1) ? RUN : FLUSH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            pc_q    <= RESET_ADDR;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
            rcnt_q  <= rcnt_d;
        end
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed scoreboard bench for pc_ctrl (CNT_W=4 to reach saturation quickly).
module tb_pc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_flag_i = 1'b0;
    logic        ext_hold_i = 1'b0;
    logic [31:0] pc_o;
    logic        flush_o, hold_o, fetch_valid_o;
    logic [3:0]  redirect_cnt_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic        fl, ho, fv;
        logic [3:0]  rc;
    } exp_t;
    exp_t q[$];

    pc_ctrl #(.RESET_ADDR(32'h0), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .ext_hold_i(ext_hold_i), .pc_o(pc_o),
        .flush_o(flush_o), .hold_o(hold_o), .fetch_valid_o(fetch_valid_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, queue what that cycle must show, then pop and compare.
    task automatic t(input logic r, input logic j, input logic [31:0] a, input logic hf,
                     input logic eh, input logic [31:0] pc, input logic fl, input logic ho,
                     input logic fv, input logic [3:0] rc, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = r; jump_en_i = j; jump_addr_i = a; hold_flag_i = hf; ext_hold_i = eh;
        q.push_back('{pc, fl, ho, fv, rc});
        #1;
        e = q.pop_front();
        chk({tag, " pc"}, pc_o, e.pc);
        chk({tag, " flush"}, {31'b0, flush_o}, {31'b0, e.fl});
        chk({tag, " hold"}, {31'b0, hold_o}, {31'b0, e.ho});
        chk({tag, " fv"}, {31'b0, fetch_valid_o}, {31'b0, e.fv});
        chk({tag, " cnt"}, {28'b0, redirect_cnt_o}, {28'b0, e.rc});
    endtask

    initial begin
        t(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, "rst0");
        t(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, "rst1");
        for (int i = 0; i < 4; i++) t(1, 0, 0, 0, 0, 32'(4 * i), 0, 0, 1, 0, "step");
        t(1, 1, 32'h100, 0, 0, 32'h10, 1, 0, 0, 0, "jmp100");
        t(1, 0, 0, 0, 0, 32'h100, 1, 0, 0, 1, "fl100");
        t(1, 0, 0, 0, 0, 32'h104, 0, 0, 1, 1, "run104");
        t(1, 1, 32'h1C, 0, 0, 32'h108, 1, 0, 0, 1, "jmp1c");
        t(1, 0, 0, 0, 0, 32'h1C, 1, 0, 0, 2, "fl1c");
        for (int i = 0; i < 3; i++) t(1, 0, 0, 0, 1, 32'h20, 0, 1, 0, 2, "exthold");
        t(1, 0, 0, 0, 0, 32'h20, 0, 0, 1, 2, "rel20");
        t(1, 0, 0, 0, 0, 32'h24, 0, 0, 1, 2, "run24");
        t(1, 1, 32'h200, 0, 0, 32'h28, 1, 0, 0, 2, "jmp200");
        for (int i = 0; i < 3; i++) t(1, 0, 0, 1, 0, 32'h200, 1, 1, 0, 3, "flhold");
        t(1, 0, 0, 0, 0, 32'h200, 1, 0, 0, 3, "flrel");
        t(1, 0, 0, 0, 0, 32'h204, 0, 0, 1, 3, "run204");
        t(1, 1, 32'h300, 0, 0, 32'h208, 1, 0, 0, 3, "jmp300");
        t(1, 1, 32'h400, 0, 0, 32'h300, 1, 0, 0, 4, "jmp400");
        t(1, 0, 0, 0, 0, 32'h400, 1, 0, 0, 5, "fl400");
        t(1, 0, 0, 0, 0, 32'h404, 0, 0, 1, 5, "run404");
        t(1, 1, 32'h503, 0, 0, 32'h408, 1, 0, 0, 5, "jmp503");
        t(1, 0, 0, 0, 0, 32'h500, 1, 0, 0, 6, "align500");
        t(1, 0, 0, 0, 0, 32'h504, 0, 0, 1, 6, "run504");
        t(1, 1, 32'h600, 0, 1, 32'h508, 1, 0, 0, 6, "jmphold");
        t(1, 0, 0, 0, 0, 32'h600, 1, 0, 0, 7, "fl600");
        t(1, 0, 0, 0, 0, 32'h604, 0, 0, 1, 7, "run604");
        t(0, 1, 32'h700, 0, 0, 32'h608, 1, 0, 0, 7, "jmprst");
        t(1, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, "afterrst");
        t(1, 1, 32'h800, 0, 0, 32'h4, 1, 0, 0, 0, "jmp800");
        t(0, 0, 0, 0, 0, 32'h800, 1, 0, 0, 1, "rstflush");
        t(1, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, "rstrun");
        t(1, 1, 32'hFFFF_FFFC, 0, 0, 32'h4, 1, 0, 0, 0, "jmptop");
        t(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 1, "fltop");
        t(1, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, "wrap");
        t(1, 0, 0, 0, 0, 32'h4, 0, 0, 1, 1, "run4");
        for (int i = 0; i < 17; i++)
            t(1, 1, 32'h1000, 0, 0, i == 0 ? 32'h8 : 32'h1000, 1, 0, 0,
              4'(i + 1 > 15 ? 15 : i + 1), "satjmp");
        t(1, 0, 0, 0, 0, 32'h1000, 1, 0, 0, 4'hF, "satfl");
        t(1, 0, 0, 0, 0, 32'h1004, 0, 0, 1, 4'hF, "sathold");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
